// File: rtl/sensor_fifo_wb_slave_pkg.sv
// Register map, bit positions and small helpers shared by the sensor FIFO
// Wishbone responder and its storage.
package sensor_fifo_wb_slave_pkg;
  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_THRESH = 3'd3;
  localparam logic [2:0] REG_ERR    = 3'd4;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_FLUSH = 1;
  localparam int CTRL_IRQEN = 2;
  localparam int CTRL_CLR   = 3;

  localparam int ST_EMPTY = 5;
  localparam int ST_FULL  = 6;
  localparam int ST_OVF   = 7;

  // Sticky error flags, packed so they read back directly as the ERR register
  typedef struct packed {
    logic ovf;
    logic unf;
  } err_flags_t;

  function automatic logic adr_mapped(input logic [2:0] a);
    return a <= REG_ERR;
  endfunction
endpackage

// File: rtl/sensor_fifo_wb_slave_if.sv
// Wishbone B3 classic bus bundle between an 8-bit, 3-bit-address initiator
// and the sensor FIFO responder.
interface sensor_fifo_wb_slave_if #(
  parameter int DWIDTH = 8
);
  logic [2:0]        adr;
  logic [DWIDTH-1:0] din;
  logic [DWIDTH-1:0] dout;
  logic              cyc;
  logic              stb;
  logic              we;
  logic              ack;
  logic              err;

  modport master (output adr, din, cyc, stb, we, input dout, ack, err);
  modport slave  (input adr, din, cyc, stb, we, output dout, ack, err);
endinterface

// File: rtl/sensor_fifo_wb_slave_sync_fifo.sv
// Show-ahead synchronous FIFO; trusts push/pop, overflow policy lives upstream.
// Flush has priority over push and pop.
module sensor_fifo_wb_slave_sync_fifo #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [DWIDTH-1:0] data_i,
  output logic [DWIDTH-1:0] head_o,
  output logic [PTR_W:0]    count_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam logic [PTR_W-1:0] PONE = 1;
  localparam logic [PTR_W:0]   CONE = 1;

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q;

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PONE;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PONE;
      if (push_i && !pop_i)      count_q <= count_q + CONE;
      else if (pop_i && !push_i) count_q <= count_q - CONE;
    end
  end
endmodule

// File: rtl/sensor_fifo_wb_slave.sv
// Wishbone responder buffering edge-detected sensor samples in a FIFO, with
// status/control/threshold/error registers and a threshold/overflow interrupt.
module sensor_fifo_wb_slave
  import sensor_fifo_wb_slave_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  sensor_fifo_wb_slave_if.slave   bus,
  input  logic [DWIDTH-1:0]       sens_data_i,
  input  logic                    sens_data_i_val,
  output logic                    irq_o
);
  localparam logic [PTR_W:0] CONE       = 1;
  localparam logic [PTR_W:0] THRESH_RST = 8;

  logic              ack_q, ack_d, err_q, err_d, irq_q, irq_d, val_q;
  logic              en_q, en_d, irq_en_q, irq_en_d;
  logic [DWIDTH-1:0] dout_q, dout_d, rdata;
  logic [PTR_W:0]    thresh_q, thresh_d, cnt_nxt;
  err_flags_t        flags_q, flags_d;

  logic [DWIDTH-1:0] head;
  logic [PTR_W:0]    count;
  logic              full, empty;
  logic              req, rd_dat, wr_ctrl, wr_thr, pop, push_req, push, flush, clr;
  logic              ovf_set, unf_set;
  logic              unused_din;

  assign req      = bus.cyc & bus.stb & ~ack_q & ~err_q;
  assign rd_dat   = req & ~bus.we & (bus.adr == REG_DATA);
  assign pop      = rd_dat & ~empty;
  assign unf_set  = rd_dat & empty;
  assign wr_ctrl  = req & bus.we & (bus.adr == REG_CTRL);
  assign wr_thr   = req & bus.we & (bus.adr == REG_THRESH);
  assign flush    = wr_ctrl & bus.din[CTRL_FLUSH];
  assign clr      = wr_ctrl & bus.din[CTRL_CLR];
  assign push_req = sens_data_i_val & ~val_q & en_q;
  // A full FIFO still accepts a sample if the head leaves on the same edge
  assign push     = push_req & ~flush & (~full | pop);
  assign ovf_set  = push_req & ~flush & full & ~pop;

  assign unused_din = &{1'b0, bus.din};

  sensor_fifo_wb_slave_sync_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  (sens_data_i),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    rdata = '0;
    case (bus.adr)
      REG_DATA:   rdata = empty ? '0 : head;
      REG_STATUS: begin
        rdata[PTR_W:0]  = count;
        rdata[ST_EMPTY] = empty;
        rdata[ST_FULL]  = full;
        rdata[ST_OVF]   = flags_q.ovf;
      end
      REG_CTRL: begin
        rdata[CTRL_EN]    = en_q;
        rdata[CTRL_IRQEN] = irq_en_q;
      end
      REG_THRESH: rdata[PTR_W:0] = thresh_q;
      REG_ERR:    rdata[1:0]     = flags_q;
      default:    rdata = '0;
    endcase
  end

  always_comb begin
    ack_d    = req & adr_mapped(bus.adr);
    err_d    = req & ~adr_mapped(bus.adr);
    dout_d   = ack_d ? rdata : '0;
    en_d     = wr_ctrl ? bus.din[CTRL_EN]    : en_q;
    irq_en_d = wr_ctrl ? bus.din[CTRL_IRQEN] : irq_en_q;
    thresh_d = wr_thr  ? bus.din[PTR_W:0]    : thresh_q;
    // A fresh overflow on the clearing edge survives the clear
    flags_d.ovf = (flags_q.ovf & ~clr) | ovf_set;
    flags_d.unf = (flags_q.unf & ~clr) | unf_set;
    cnt_nxt = count;
    if (flush)                cnt_nxt = '0;
    else if (push && !pop)    cnt_nxt = count + CONE;
    else if (pop && !push)    cnt_nxt = count - CONE;
    irq_d = irq_en_d & ((cnt_nxt >= thresh_d) | flags_d.ovf);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dout_q   <= '0;
      irq_q    <= 1'b0;
      val_q    <= 1'b0;
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      thresh_q <= THRESH_RST;
      flags_q  <= '0;
    end else begin
      ack_q    <= ack_d;
      err_q    <= err_d;
      dout_q   <= dout_d;
      irq_q    <= irq_d;
      val_q    <= sens_data_i_val;
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      thresh_q <= thresh_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.ack  = ack_q;
  assign bus.err  = err_q;
  assign bus.dout = dout_q;
  assign irq_o    = irq_q;
endmodule

// File: tb/tb_sensor_fifo_wb_slave.sv
// Scoreboarded bench for the sensor FIFO Wishbone responder.
module tb_sensor_fifo_wb_slave;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sens_data;
  logic       sens_val;
  logic       irq;

  always #5 clk = ~clk;

  sensor_fifo_wb_slave_if #(.DWIDTH(8)) bus ();

  sensor_fifo_wb_slave #(.DWIDTH(8), .DEPTH(16), .PTR_W(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .sens_data_i     (sens_data),
    .sens_data_i_val (sens_val),
    .irq_o           (irq)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] mdl_q [$];
  logic [7:0] exp_q [$];
  bit         en_m = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic [2:0] a, input logic w, input logic [7:0] d,
                      output logic [7:0] rd_v, output logic ak, output logic er);
    int n = 0;
    @(negedge clk);
    bus.adr = a; bus.we = w; bus.din = d; bus.cyc = 1'b1; bus.stb = 1'b1;
    do begin
      @(posedge clk); #1; n++;
    end while (!bus.ack && !bus.err && n < 8);
    rd_v = bus.dout; ak = bus.ack; er = bus.err;
    @(negedge clk);
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    @(posedge clk); #1;
    chk("pulse", {31'b0, bus.ack | bus.err}, 32'd0);
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] v;
    logic ak, er;
    exp_q.push_back(exp);
    xfer(a, 1'b0, 8'h00, v, ak, er);
    chk({tag, "_ack"}, {31'b0, ak}, 32'd1);
    chk(tag, {24'b0, v}, {24'b0, exp_q.pop_front()});
  endtask

  task automatic rd_fifo(input string tag);
    rd(tag, 3'd0, (mdl_q.size() > 0) ? mdl_q.pop_front() : 8'h00);
  endtask

  task automatic wr(input string tag, input logic [2:0] a, input logic [7:0] d);
    logic [7:0] v;
    logic ak, er;
    xfer(a, 1'b1, d, v, ak, er);
    chk({tag, "_ack"}, {31'b0, ak}, 32'd1);
    if (a == 3'd2) begin
      en_m = d[0];
      if (d[1]) mdl_q.delete();
    end
  endtask

  task automatic push_sample(input logic [7:0] d);
    @(negedge clk);
    sens_data = d; sens_val = 1'b1;
    if (en_m && mdl_q.size() < 16) mdl_q.push_back(d);
    repeat (2) @(negedge clk);
    sens_val = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] v;
    logic ak, er;
    int n;
    bus.adr = '0; bus.din = '0; bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    sens_data = '0; sens_val = 1'b0; rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", {24'b0, bus.dout}, 32'd0);
    chk("rst_ack", {31'b0, bus.ack}, 32'd0);
    chk("rst_err", {31'b0, bus.err}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    @(negedge clk) rst = 1'b0;

    rd("st_rst", 3'd1, 8'h20);
    rd("thr_rst", 3'd3, 8'h08);
    rd("ctrl_rst", 3'd2, 8'h00);

    wr("en", 3'd2, 8'h01);
    push_sample(8'hA1); push_sample(8'hB2); push_sample(8'hC3);
    rd("st3", 3'd1, 8'h03);
    rd_fifo("d0"); rd_fifo("d1"); rd_fifo("d2");
    rd("st_drained", 3'd1, 8'h20);

    for (int i = 0; i < 17; i++) push_sample(8'h10 + 8'(i));
    rd("st_full", 3'd1, 8'hD0);
    rd("err_ovf", 3'd4, 8'h02);
    wr("clr", 3'd2, 8'h09);
    rd("st_clr", 3'd1, 8'h50);

    wr("flush", 3'd2, 8'h03);
    rd("st_flush", 3'd1, 8'h20);
    rd_fifo("d_unf");
    rd("err_unf", 3'd4, 8'h01);
    for (int i = 0; i < 16; i++) push_sample(8'h40 + 8'(i));
    rd("st_refull", 3'd1, 8'h50);

    // DATA pop and a sample edge sampled on the same clock edge while full
    exp_q.push_back(mdl_q.pop_front());
    mdl_q.push_back(8'h5A);
    @(negedge clk);
    bus.adr = 3'd0; bus.we = 1'b0; bus.cyc = 1'b1; bus.stb = 1'b1;
    sens_data = 8'h5A; sens_val = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!bus.ack && n < 8);
    chk("pp_ack", {31'b0, bus.ack}, 32'd1);
    chk("pp_data", {24'b0, bus.dout}, {24'b0, exp_q.pop_front()});
    @(negedge clk);
    bus.cyc = 1'b0; bus.stb = 1'b0;
    @(negedge clk) sens_val = 1'b0;
    rd("st_pushpop", 3'd1, 8'h50);
    rd("err_pushpop", 3'd4, 8'h01);

    wr("flush_clr", 3'd2, 8'h0B);
    rd("err_clr", 3'd4, 8'h00);
    wr("thr2", 3'd3, 8'h02);
    wr("irq_en", 3'd2, 8'h05);
    chk("irq_idle", {31'b0, irq}, 32'd0);
    push_sample(8'h01);
    chk("irq_one", {31'b0, irq}, 32'd0);
    @(negedge clk);
    sens_data = 8'h02; sens_val = 1'b1;
    mdl_q.push_back(8'h02);
    chk("irq_pre", {31'b0, irq}, 32'd0);
    @(posedge clk); #1;
    chk("irq_rise", {31'b0, irq}, 32'd1);
    @(negedge clk) sens_val = 1'b0;
    repeat (2) @(negedge clk);
    chk("irq_hold", {31'b0, irq}, 32'd1);
    rd_fifo("d_irq");
    chk("irq_fall", {31'b0, irq}, 32'd0);
    xfer(3'd6, 1'b0, 8'h00, v, ak, er);
    chk("unmap_ack", {31'b0, ak}, 32'd0);
    chk("unmap_err", {31'b0, er}, 32'd1);
    chk("unmap_dout", {24'b0, v}, 32'd0);

    wr("flush6", 3'd2, 8'h03);
    for (int i = 0; i < 5; i++) push_sample(8'h70 + 8'(i));
    rd("st5", 3'd1, 8'h05);
    @(negedge clk);
    bus.adr = 3'd1; bus.we = 1'b0; bus.cyc = 1'b1; bus.stb = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_xfer_ack", {31'b0, bus.ack}, 32'd0);
    @(negedge clk);
    bus.cyc = 1'b0; bus.stb = 1'b0; rst = 1'b0;
    mdl_q.delete(); en_m = 0;
    @(posedge clk); #1;
    chk("rst_xfer_ack2", {31'b0, bus.ack}, 32'd0);
    chk("rst_xfer_irq", {31'b0, irq}, 32'd0);
    rd("st_after_rst", 3'd1, 8'h20);
    rd("ctrl_after_rst", 3'd2, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
